// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: synchroniser, tick-paced debouncer, edge pulses and auto-repeat FSM.
module key_chan
  import key_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEB_SAMPLES  = 4,
  parameter int unsigned REPEAT_DELAY = 32,
  parameter int unsigned REPEAT_RATE  = 8,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic key_raw_i,
  input  logic repeat_en_i,
  output logic key_level_o,
  output logic key_press_o,
  output logic key_release_o,
  output logic key_event_o
);

  localparam int unsigned RLIM = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned DW   = cnt_width(DEB_SAMPLES);
  localparam int unsigned RW   = cnt_width(RLIM);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample_c;

  logic          level_q, level_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          rise_c, fall_c;

  rpt_state_t    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  logic press_q, release_q, event_q, event_d;

  // Input synchroniser; polarity is normalised after the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw_i};
  end

  assign sample_c = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Debouncer: accept a new level only after DEB_SAMPLES consecutive differing ticks.
  always_comb begin
    level_d = level_q;
    dcnt_d  = dcnt_q;
    rise_c  = 1'b0;
    fall_c  = 1'b0;
    if (tick_i) begin
      if (sample_c == level_q) begin
        dcnt_d = '0;
      end else if (dcnt_q == DW'(DEB_SAMPLES - 1)) begin
        level_d = ~level_q;
        dcnt_d  = '0;
        rise_c  = ~level_q;
        fall_c  = level_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  // Repeat FSM next-state; the press itself always produces an event.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    event_d = rise_c;
    case (state_q)
      IDLE: begin
        if (rise_c && repeat_en_i) begin
          state_d = DELAY;
          rcnt_d  = '0;
        end
      end
      DELAY: begin
        if (fall_c || !repeat_en_i) begin
          state_d = IDLE;
          rcnt_d  = '0;
          event_d = 1'b0;
        end else if (tick_i) begin
          if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
            event_d = 1'b1;
            state_d = REPEAT;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end
      REPEAT: begin
        if (fall_c || !repeat_en_i) begin
          state_d = IDLE;
          rcnt_d  = '0;
          event_d = 1'b0;
        end else if (tick_i) begin
          if (rcnt_q == RW'(REPEAT_RATE - 1)) begin
            event_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      dcnt_q    <= '0;
      state_q   <= IDLE;
      rcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      event_q   <= 1'b0;
    end else begin
      level_q   <= level_d;
      dcnt_q    <= dcnt_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      press_q   <= rise_c;
      release_q <= fall_c;
      event_q   <= event_d;
    end
  end

  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign key_event_o   = event_q;

endmodule

// File: rtl/key_input_ctrl.sv
// N-channel push-button conditioner with one shared sample-tick generator.
module key_input_ctrl
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS       = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TICK_DIV     = 50,
  parameter int unsigned DEB_SAMPLES  = 4,
  parameter int unsigned REPEAT_DELAY = 32,
  parameter int unsigned REPEAT_RATE  = 8,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw_i,
  input  logic [N_KEYS-1:0] repeat_en_i,
  output logic [N_KEYS-1:0] key_level_o,
  output logic [N_KEYS-1:0] key_press_o,
  output logic [N_KEYS-1:0] key_release_o,
  output logic [N_KEYS-1:0] key_event_o,
  output logic              tick_o
);

  localparam int unsigned TW = cnt_width(TICK_DIV);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tick_q, tick_d;

  // tick_q is registered so it is high exactly while tcnt_q == TICK_DIV-1.
  always_comb begin
    tcnt_d = (tcnt_q == TW'(TICK_DIV - 1)) ? '0 : tcnt_q + TW'(1);
    tick_d = (tcnt_d == TW'(TICK_DIV - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_SAMPLES (DEB_SAMPLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick_i       (tick_q),
      .key_raw_i    (key_raw_i[g]),
      .repeat_en_i  (repeat_en_i[g]),
      .key_level_o  (key_level_o[g]),
      .key_press_o  (key_press_o[g]),
      .key_release_o(key_release_o[g]),
      .key_event_o  (key_event_o[g])
    );
  end

endmodule
